// File: rtl/alu_issue_queue.sv
// Age-ordered collapsing issue queue feeding the integer ALU.
// Operands wake up from result broadcasts; the oldest fully-ready entry is offered each cycle.
module alu_issue_queue #(
    parameter int DEPTH  = 4,
    parameter int TAG_W  = 6,
    parameter int NUM_WB = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         disp_valid,
    output logic                         disp_ready,
    input  logic [4:0]                   disp_alu_ops,
    input  logic [31:0]                  disp_op1,
    input  logic [31:0]                  disp_op2,
    input  logic                         disp_op1_valid,
    input  logic                         disp_op2_valid,
    input  logic [TAG_W-1:0]             disp_op1_tag,
    input  logic [TAG_W-1:0]             disp_op2_tag,
    input  logic [TAG_W-1:0]             disp_dst_tag,
    input  logic [NUM_WB-1:0]            wb_valid,
    input  logic [NUM_WB*TAG_W-1:0]      wb_tag,
    input  logic [NUM_WB*32-1:0]         wb_data,
    output logic                         issue_valid,
    input  logic                         issue_ready,
    output logic [4:0]                   issue_alu_ops,
    output logic [31:0]                  issue_op1,
    output logic [31:0]                  issue_op2,
    output logic [TAG_W-1:0]             issue_dst_tag,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int IW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    // Scanning from the highest port down lets the lowest matching port win.
    function automatic logic [32:0] wakeOperand(
        input logic                     v,
        input logic [TAG_W-1:0]         t,
        input logic [31:0]              d,
        input logic [NUM_WB-1:0]        wv,
        input logic [NUM_WB*TAG_W-1:0]  wt,
        input logic [NUM_WB*32-1:0]     wd
    );
        logic [32:0] res;
        res = {v, d};
        if (!v) begin
            for (int p = NUM_WB - 1; p >= 0; p--) begin
                if (wv[p] && (wt[p*TAG_W +: TAG_W] == t)) begin
                    res = {1'b1, wd[p*32 +: 32]};
                end
            end
        end
        return res;
    endfunction

    logic [4:0]       r_ops [DEPTH];
    logic [TAG_W-1:0] r_dst [DEPTH];
    logic             r_v1  [DEPTH];
    logic [TAG_W-1:0] r_t1  [DEPTH];
    logic [31:0]      r_d1  [DEPTH];
    logic             r_v2  [DEPTH];
    logic [TAG_W-1:0] r_t2  [DEPTH];
    logic [31:0]      r_d2  [DEPTH];
    logic [CW-1:0]    r_count;

    logic [4:0]       w_nOps [DEPTH];
    logic [TAG_W-1:0] w_nDst [DEPTH];
    logic             w_nV1  [DEPTH];
    logic [TAG_W-1:0] w_nT1  [DEPTH];
    logic [31:0]      w_nD1  [DEPTH];
    logic             w_nV2  [DEPTH];
    logic [TAG_W-1:0] w_nT2  [DEPTH];
    logic [31:0]      w_nD2  [DEPTH];

    logic [DEPTH-1:0] w_rdy;
    logic             w_selFound;
    logic [IW-1:0]    w_selIdx;
    logic             w_issueFire;
    logic             w_dispFire;
    logic [CW-1:0]    w_wrIdx;
    logic             w_dispV1;
    logic [31:0]      w_dispD1;
    logic             w_dispV2;
    logic [31:0]      w_dispD2;

    always_comb begin
        w_selFound = 1'b0;
        w_selIdx   = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (w_rdy[i]) begin
                w_selFound = 1'b1;
                w_selIdx   = IW'(i);
            end
        end
    end

    assign disp_ready  = (r_count < CW'(DEPTH));
    assign count       = r_count;
    assign w_issueFire = w_selFound && issue_ready && !flush;
    assign w_dispFire  = disp_valid && disp_ready && !flush;
    assign w_wrIdx     = r_count - CW'(w_issueFire);

    assign {w_dispV1, w_dispD1} = wakeOperand(disp_op1_valid, disp_op1_tag, disp_op1, wb_valid, wb_tag, wb_data);
    assign {w_dispV2, w_dispD2} = wakeOperand(disp_op2_valid, disp_op2_tag, disp_op2, wb_valid, wb_tag, wb_data);

    assign issue_valid   = w_selFound;
    assign issue_alu_ops = w_selFound ? r_ops[w_selIdx] : '0;
    assign issue_op1     = w_selFound ? r_d1[w_selIdx]  : '0;
    assign issue_op2     = w_selFound ? r_d2[w_selIdx]  : '0;
    assign issue_dst_tag = w_selFound ? r_dst[w_selIdx] : '0;

    // Each slot takes its own or its upper neighbour's contents, wakes them, then may be overwritten by dispatch.
    for (genvar g = 0; g < DEPTH; g++) begin : gEntry
        logic             w_shift;
        logic             w_wr;
        logic [4:0]       w_sOps;
        logic [TAG_W-1:0] w_sDst;
        logic             w_sV1;
        logic [TAG_W-1:0] w_sT1;
        logic [31:0]      w_sD1;
        logic             w_sV2;
        logic [TAG_W-1:0] w_sT2;
        logic [31:0]      w_sD2;
        logic             w_wV1;
        logic [31:0]      w_wD1;
        logic             w_wV2;
        logic [31:0]      w_wD2;

        assign w_shift  = w_issueFire && (w_selIdx <= IW'(g));
        assign w_wr     = w_dispFire && (w_wrIdx == CW'(g));
        assign w_rdy[g] = (r_count > CW'(g)) && r_v1[g] && r_v2[g];

        if (g < DEPTH - 1) begin : gShift
            assign w_sOps = w_shift ? r_ops[g+1] : r_ops[g];
            assign w_sDst = w_shift ? r_dst[g+1] : r_dst[g];
            assign w_sV1  = w_shift ? r_v1[g+1]  : r_v1[g];
            assign w_sT1  = w_shift ? r_t1[g+1]  : r_t1[g];
            assign w_sD1  = w_shift ? r_d1[g+1]  : r_d1[g];
            assign w_sV2  = w_shift ? r_v2[g+1]  : r_v2[g];
            assign w_sT2  = w_shift ? r_t2[g+1]  : r_t2[g];
            assign w_sD2  = w_shift ? r_d2[g+1]  : r_d2[g];
        end else begin : gTop
            assign w_sOps = r_ops[g];
            assign w_sDst = r_dst[g];
            assign w_sV1  = r_v1[g];
            assign w_sT1  = r_t1[g];
            assign w_sD1  = r_d1[g];
            assign w_sV2  = r_v2[g];
            assign w_sT2  = r_t2[g];
            assign w_sD2  = r_d2[g];
        end

        assign {w_wV1, w_wD1} = wakeOperand(w_sV1, w_sT1, w_sD1, wb_valid, wb_tag, wb_data);
        assign {w_wV2, w_wD2} = wakeOperand(w_sV2, w_sT2, w_sD2, wb_valid, wb_tag, wb_data);

        assign w_nOps[g] = w_wr ? disp_alu_ops : w_sOps;
        assign w_nDst[g] = w_wr ? disp_dst_tag : w_sDst;
        assign w_nV1[g]  = w_wr ? w_dispV1     : w_wV1;
        assign w_nT1[g]  = w_wr ? disp_op1_tag : w_sT1;
        assign w_nD1[g]  = w_wr ? w_dispD1     : w_wD1;
        assign w_nV2[g]  = w_wr ? w_dispV2     : w_wV2;
        assign w_nT2[g]  = w_wr ? disp_op2_tag : w_sT2;
        assign w_nD2[g]  = w_wr ? w_dispD2     : w_wD2;
    end

    // Occupancy is defined by the count alone, so clearing it is enough to empty the queue.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CW'(w_dispFire) - CW'(w_issueFire);
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            r_ops[i] <= w_nOps[i];
            r_dst[i] <= w_nDst[i];
            r_v1[i]  <= w_nV1[i];
            r_t1[i]  <= w_nT1[i];
            r_d1[i]  <= w_nD1[i];
            r_v2[i]  <= w_nV2[i];
            r_t2[i]  <= w_nT2[i];
            r_d2[i]  <= w_nD2[i];
        end
    end

endmodule

// File: doc/alu_issue_queue.md
# alu_issue_queue

In-order-aged issue queue that sits directly upstream of the integer ALU in the execute stage. Rename/dispatch writes ALU micro-ops into it, possibly with unresolved source operands. Operands are captured from result-broadcast (wakeup) buses. Each cycle the oldest entry with both operands ready is offered to the ALU over a valid/ready handshake.

## Interface
Parameters:
- DEPTH, 4, number of entries (≥2)
- TAG_W, 6, physical register tag width
- NUM_WB, 2, number of wakeup/broadcast ports

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- flush  in  1  discard all entries (mispredict/exception)
- disp_valid  in  1  dispatch request
- disp_ready  out  1  queue can accept a dispatch this cycle
- disp_alu_ops  in  5  ALU operation code (common package encoding)
- disp_op1, disp_op2  in  32 each  operand values, meaningful when matching *_valid=1
- disp_op1_valid, disp_op2_valid  in  1 each  operand already resolved
- disp_op1_tag, disp_op2_tag  in  TAG_W each  producer tag when not resolved
- disp_dst_tag  in  TAG_W  destination tag
- wb_valid  in  NUM_WB  per-port broadcast valid
- wb_tag  in  NUM_WB*TAG_W  broadcast tags, port i at [i*TAG_W +: TAG_W]
- wb_data  in  NUM_WB*32  broadcast data, port i at [i*32 +: 32]
- issue_valid  out  1  issue slot holds a ready micro-op
- issue_ready  in  1  ALU accepts
- issue_alu_ops  out  5, issue_op1  out  32, issue_op2  out  32, issue_dst_tag  out  TAG_W  issued micro-op
- count  out  $clog2(DEPTH+1)  occupied entries

## Operation
- Storage is a collapsing queue. Index 0 is the oldest entry. Occupied entries are always 0..count-1.
- Each entry holds: alu_ops, dst_tag, and for each operand {valid, tag, data}.
- Wakeup: for every occupied entry operand with valid=0, if any wb_valid[i] is set and wb_tag[i]==tag, the operand is set to valid=1 with data=wb_data[i]. If several ports match, the lowest port index wins. Operands already valid ignore the buses.
- Dispatch capture: an unresolved dispatched operand whose tag matches a wakeup port in the same cycle is stored as valid with that port's data. It never misses a same-cycle broadcast.
- Select: the lowest index entry with both operands valid, using registered state only. issue_valid=1 if such an entry exists, and issue_* show its fields. When issue_valid=0, issue_* outputs are driven to 0.
- Issue fires when issue_valid && issue_ready. The selected entry is removed and entries above it shift down one index, keeping their order and applying same-cycle wakeups.
- disp_ready = (count < DEPTH). Same-cycle issue does not make room.
- Dispatch fires when disp_valid && disp_ready. The new entry is written at the first free index after any same-cycle collapse: count, or count-1 if an issue fires.
- Simultaneous dispatch and issue: both take effect and count is unchanged.
- Flush has top priority: all entries are invalidated and count→0. A same-cycle dispatch or issue handshake is discarded (the ALU ignores an issue in a flush cycle).
- alu_ops is passed through unmodified. Unknown codes are not checked.

## Timing
- Reset (rst=1 at a clock edge): count=0, all entries invalid. Next cycle: disp_ready=1, issue_valid=0, issue_alu_ops/op1/op2/dst_tag=0.
- Reset or flush mid-operation loses all entries with no partial issue.
- issue_valid and issue_* are combinational from registered state. disp_ready and count are registered-state only.
- Dispatch with both operands valid in cycle N: the entry can issue in cycle N+1 (minimum latency 1).
- Wakeup of an entry's last operand in cycle N: issue_valid for it is asserted no earlier than N+1.
- Back-to-back: with issue_ready held at 1, one entry issues per cycle.
- Full: with count==DEPTH, disp_ready=0 even if an issue fires that cycle.

## Test plan
- Reset then idle: after rst, count=0, disp_ready=1, issue_valid=0, issue_op1=0. Dispatch ADD op1=5 op2=7 (both valid) in cycle 1 -> cycle 2: issue_valid=1, op1=5, op2=7, dst_tag as dispatched. issue_ready=1 -> count returns to 0 in cycle 3.
- Age order: dispatch A (op1 waiting on tag 3), then B (ready). B issues first. Broadcast tag 3 data 0x1234 on wb port 1 -> A issues the next cycle with op1=0x1234.
- Same-cycle capture: dispatch op2 unresolved tag 9 while wb_valid[0]=1, wb_tag=9, wb_data=0xDEAD -> entry issues the next cycle with op2=0xDEAD.
- Full/backpressure: hold issue_ready=0 and dispatch DEPTH ready ops -> count=4, disp_ready=0, and a further disp_valid is not accepted. Release issue_ready -> ops issue in dispatch order, one per cycle.
- Simultaneous dispatch+issue at count=2 -> count stays 2 and the new entry lands at index 1 behind the survivor. Port conflict: both wb ports carry tag 5 with different data -> port 0's data is captured.
- Flush with 3 entries plus a concurrent dispatch -> count=0 next cycle, issue_valid=0, and the flushed ops never appear on issue_*.
